// File: rtl/usb_bus_ctrl.sv
// -----------------------------------------------------------------------------
// usb_bus_ctrl
//
// Half-duplex direction controller for the shared USB dp/dn pair. Sits between
// the SIE, phy_rx and phy_tx, and decides who owns the bus:
//   - gates phy_rx through rx_en_o (receiver enabled whenever we are not
//     transmitting),
//   - holds off a transmit grant until the inter-packet delay after a received
//     EOP has elapsed,
//   - times out when a response expected after our transmission never arrives.
// All timing is in 12 MHz bit times, BIT_SAMPLES clk_i cycles per bit.
//
// Optional feature macro: USB_BUS_CTRL_ERR_CNT_EN
//   defined   : err_cnt_o is an 8-bit saturating count of receive-error exits
//               and response timeouts, cleared only by rst_i.
//   undefined : err_cnt_o is tied to zero, no counter flops.
//
// Parameters
//   BIT_SAMPLES  clk_i cycles per USB bit time
//   IPD_BITS     inter-packet delay (bit times) from received EOP to tx grant
//   TIMEOUT_BITS response timeout (bit times) from end of our transmission
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   rx_valid_i     phy_rx: packet data in progress
//   rx_ready_i     phy_rx: status strobe (EOP when !rx_valid_i && !rx_err_i)
//   rx_err_i       phy_rx: receive error qualifier for rx_ready_i
//   usb_reset_i    phy_rx: bus reset detected
//   rx_en_o        enable to phy_rx
//   tx_req_i       SIE transmit request (level)
//   wait_rx_i      SIE expects a response; sampled with tx_done_i
//   tx_done_i      phy_tx: one-cycle pulse when its EOP has been sent
//   tx_grant_o     SIE/phy_tx may drive the bus
//   timeout_o      one-cycle pulse on response timeout
//   err_cnt_o      error/timeout count (see macro above)
//   state_o        debug view of the state register:
//                  0 IDLE, 1 RX, 2 IPD, 3 TX, 4 WAIT, 5 RST
//
// Transmit handshake: tx_req_i is a level request that the SIE holds until it
// sees tx_grant_o high; tx_grant_o then stays high until the cycle after
// tx_done_i (or a bus reset), independent of tx_req_i.
// -----------------------------------------------------------------------------
module usb_bus_ctrl #(
  parameter int BIT_SAMPLES  = 4,
  parameter int IPD_BITS     = 2,
  parameter int TIMEOUT_BITS = 18
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic       rx_ready_i,
  input  logic       rx_err_i,
  input  logic       usb_reset_i,
  output logic       rx_en_o,
  input  logic       tx_req_i,
  input  logic       wait_rx_i,
  input  logic       tx_done_i,
  output logic       tx_grant_o,
  output logic       timeout_o,
  output logic [7:0] err_cnt_o,
  output logic [2:0] state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_BITS * BIT_SAMPLES + 1);
  localparam logic [CNT_W-1:0] IPD_LAST = CNT_W'(IPD_BITS * BIT_SAMPLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_BITS * BIT_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_IPD  = 3'd2,
    ST_TX   = 3'd3,
    ST_WAIT = 3'd4,
    ST_RST  = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_d;
  logic             rx_eop;
  logic             rx_error;

  assign rx_eop   = rx_ready_i & ~rx_valid_i & ~rx_err_i;
  assign rx_error = rx_ready_i & rx_err_i;

  // Next-state decode. Bus reset outranks everything, including an active
  // transmission, which is simply abandoned.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    if (usb_reset_i) begin
      state_d = ST_RST;
    end else begin
      case (state_q)
        ST_RST: state_d = ST_IDLE;
        ST_IDLE: begin
          if (rx_valid_i)    state_d = ST_RX;
          else if (tx_req_i) state_d = ST_TX;
        end
        ST_RX: begin
          if (rx_eop)        state_d = ST_IPD;
          else if (rx_error) state_d = ST_IDLE;
        end
        ST_IPD: begin
          if (rx_valid_i)               state_d = ST_RX;
          else if (cnt_q == IPD_LAST)   state_d = ST_IDLE;
        end
        ST_TX: begin
          // Receive inputs are ignored while we own the bus.
          if (tx_done_i) state_d = wait_rx_i ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          // A response arriving on the final count wins over the timeout.
          if (rx_valid_i) begin
            state_d = ST_RX;
          end else if (cnt_q == TO_LAST) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, timer and registered outputs. Outputs are decoded from the next
  // state so they line up with state_q after each edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_en_o    <= 1'b1;
      tx_grant_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == ST_IPD || state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      rx_en_o    <= (state_d != ST_TX);
      tx_grant_o <= (state_d == ST_TX);
      timeout_o  <= timeout_d;
    end
  end

  assign state_o = state_q;

`ifdef USB_BUS_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       err_event;

  // A receive error only counts when it actually causes the RX exit, i.e.
  // when a bus reset is not taking priority in the same cycle.
  assign err_event = (~usb_reset_i & (state_q == ST_RX) & rx_error) | timeout_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= 8'd0;
    end else if (err_event && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_bus_ctrl
//
// Drives usb_bus_ctrl with directed scenarios followed by random traffic and
// compares every cycle against a behavioural model. The model tracks which
// party owns the bus plus an absolute deadline (in clock edges) for the
// inter-packet gap and the response timeout, rather than a running counter.
// -----------------------------------------------------------------------------
module tb_usb_bus_ctrl;

  localparam int BS      = 4;
  localparam int IPD_CYC = 2 * BS;
  localparam int TO_CYC  = 18 * BS;

  // Bus-ownership modes, numbered as the debug state output reports them.
  localparam int M_IDLE = 0;
  localparam int M_RX   = 1;
  localparam int M_GAP  = 2;
  localparam int M_TX   = 3;
  localparam int M_WAIT = 4;
  localparam int M_BRST = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rx_valid, rx_ready, rx_err, usb_reset;
  logic       tx_req, wait_rx, tx_done;
  logic       rx_en, tx_grant, timeout;
  logic [7:0] err_cnt;
  logic [2:0] state;

  usb_bus_ctrl #(.BIT_SAMPLES(BS), .IPD_BITS(2), .TIMEOUT_BITS(18)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_valid_i (rx_valid),
    .rx_ready_i (rx_ready),
    .rx_err_i   (rx_err),
    .usb_reset_i(usb_reset),
    .rx_en_o    (rx_en),
    .tx_req_i   (tx_req),
    .wait_rx_i  (wait_rx),
    .tx_done_i  (tx_done),
    .tx_grant_o (tx_grant),
    .timeout_o  (timeout),
    .err_cnt_o  (err_cnt),
    .state_o    (state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   edge_no;
  int   m_mode;
  int   m_deadline;
  int   m_errs;
  logic m_to;

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_deadline = 0;
    m_errs     = 0;
    m_to       = 1'b0;
  endtask

  // Apply the inputs present at this clock edge to the model.
  task automatic model_edge();
    logic eop, rerr;
    eop  = rx_ready & ~rx_valid & ~rx_err;
    rerr = rx_ready & rx_err;
    m_to = 1'b0;
    if (usb_reset) begin
      m_mode = M_BRST;
    end else if (m_mode == M_BRST) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (rx_valid)    m_mode = M_RX;
      else if (tx_req) m_mode = M_TX;
    end else if (m_mode == M_RX) begin
      if (eop) begin
        m_mode     = M_GAP;
        m_deadline = edge_no + IPD_CYC;
      end else if (rerr) begin
        m_mode = M_IDLE;
        m_errs++;
      end
    end else if (m_mode == M_GAP) begin
      if (rx_valid)                  m_mode = M_RX;
      else if (edge_no == m_deadline) m_mode = M_IDLE;
    end else if (m_mode == M_TX) begin
      if (tx_done) begin
        if (wait_rx) begin
          m_mode     = M_WAIT;
          m_deadline = edge_no + TO_CYC;
        end else begin
          m_mode = M_IDLE;
        end
      end
    end else if (m_mode == M_WAIT) begin
      if (rx_valid) begin
        m_mode = M_RX;
      end else if (edge_no == m_deadline) begin
        m_mode = M_IDLE;
        m_to   = 1'b1;
        m_errs++;
      end
    end
  endtask

  function automatic logic [7:0] exp_err_cnt();
`ifdef USB_BUS_CTRL_ERR_CNT_EN
    return (m_errs > 255) ? 8'd255 : 8'(m_errs);
`else
    return 8'd0;
`endif
  endfunction

  task automatic compare_all();
    check("rx_en",    32'(rx_en),    32'(m_mode != M_TX));
    check("tx_grant", 32'(tx_grant), 32'(m_mode == M_TX));
    check("timeout",  32'(timeout),  32'(m_to));
    check("err_cnt",  32'(err_cnt),  32'(exp_err_cnt()));
    check("state",    32'(state),    32'(m_mode));
  endtask

  // One clock: model sees the edge's inputs, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    compare_all();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  int lat;
  int exp_errs_now;

  initial begin
    rst = 1'b1;
    rx_valid = 0; rx_ready = 0; rx_err = 0; usb_reset = 0;
    tx_req = 0; wait_rx = 0; tx_done = 0;
    edge_no = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rx_en",    32'(rx_en),    32'd1);
    check("rst_tx_grant", 32'(tx_grant), 32'd0);
    check("rst_timeout",  32'(timeout),  32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    check("rst_state",    32'(state),    32'(M_IDLE));

    // Receive then respond: grant exactly IPD_CYC+2 cycles after the EOP.
    rx_valid = 1; tx_req = 1;
    repeat (20) tick();
    rx_valid = 0; rx_ready = 1;
    tick();
    lat = 1;
    rx_ready = 0;
    while (!tx_grant && lat < 50) begin
      tick();
      lat++;
    end
    check("ipd_latency", 32'(lat), 32'(IPD_CYC + 2));
    tx_req = 0;
    repeat (3) tick();
    check("tx_hold_after_req_drop", 32'(tx_grant), 32'd1);

    // Response timeout.
    tx_done = 1; wait_rx = 1;
    tick();
    lat = 1;
    tx_done = 0; wait_rx = 0;
    while (!timeout && lat < 200) begin
      tick();
      lat++;
    end
    check("timeout_latency", 32'(lat), 32'(TO_CYC + 1));
    check("timeout_state", 32'(state), 32'(M_IDLE));
`ifdef USB_BUS_CTRL_ERR_CNT_EN
    exp_errs_now = 1;
`else
    exp_errs_now = 0;
`endif
    check("timeout_err_cnt", 32'(err_cnt), 32'(exp_errs_now));
    tick();
    check("timeout_single", 32'(timeout), 32'd0);

    // Timeout race: response arrives on the last count.
    tx_req = 1;
    tick();
    tx_req = 0;
    tick();
    tx_done = 1; wait_rx = 1;
    tick();
    tx_done = 0; wait_rx = 0;
    repeat (TO_CYC - 1) tick();
    rx_valid = 1;
    tick();
    check("race_state",   32'(state),   32'(M_RX));
    check("race_timeout", 32'(timeout), 32'd0);
    check("race_err_cnt", 32'(err_cnt), 32'(exp_errs_now));
    rx_valid = 0; rx_ready = 1;
    tick();
    rx_ready = 0;
    repeat (IPD_CYC + 1) tick();

    // Bus reset aborts a transmission.
    tx_req = 1;
    tick();
    check("abort_grant_before", 32'(tx_grant), 32'd1);
    tx_req = 0;
    tick();
    usb_reset = 1;
    tick();
    check("abort_grant", 32'(tx_grant), 32'd0);
    check("abort_rx_en", 32'(rx_en),    32'd1);
    repeat (4) tick();
    usb_reset = 0;
    tick();
    check("abort_idle", 32'(state), 32'(M_IDLE));

    // 300 error exits, each followed by an immediate grant.
    for (int i = 0; i < 300; i++) begin
      rx_valid = 1; tx_req = 1;
      tick();
      tick();
      rx_valid = 0; rx_ready = 1; rx_err = 1;
      tick();
      rx_ready = 0; rx_err = 0;
      tick();
      check("err_grant", 32'(tx_grant), 32'd1);
      tx_req = 0; tx_done = 1; wait_rx = 0;
      tick();
      tx_done = 0;
    end
`ifdef USB_BUS_CTRL_ERR_CNT_EN
    check("err_saturate", 32'(err_cnt), 32'd255);
`else
    check("err_tied_zero", 32'(err_cnt), 32'd0);
`endif

    // Asynchronous reset while waiting for a response.
    tx_req = 1;
    tick();
    tx_req = 0;
    tx_done = 1; wait_rx = 1;
    tick();
    tx_done = 0; wait_rx = 0;
    repeat (10) tick();
    check("pre_arst_state", 32'(state), 32'(M_WAIT));
    #3;
    rst = 1'b1;
    #1;
    check("arst_rx_en",    32'(rx_en),    32'd1);
    check("arst_tx_grant", 32'(tx_grant), 32'd0);
    check("arst_timeout",  32'(timeout),  32'd0);
    check("arst_err_cnt",  32'(err_cnt),  32'd0);
    check("arst_state",    32'(state),    32'(M_IDLE));
    model_reset();
    @(posedge clk);
    edge_no++;
    #1;
    rst = 1'b0;
    compare_all();

    // Random traffic in segments of quiet or busy receive activity.
    for (int seg = 0; seg < 40; seg++) begin
      int p_valid;
      p_valid = ($urandom_range(0, 1) == 0) ? 1 : 30;
      for (int c = 0; c < 100; c++) begin
        rx_valid  = ($urandom_range(0, 99) < p_valid);
        rx_ready  = ($urandom_range(0, 99) < 10);
        rx_err    = ($urandom_range(0, 99) < 30);
        usb_reset = ($urandom_range(0, 999) < 5);
        tx_req    = ($urandom_range(0, 99) < 40);
        tx_done   = ($urandom_range(0, 99) < 8);
        wait_rx   = ($urandom_range(0, 99) < 60);
        tick();
      end
    end
    rx_valid = 0; rx_ready = 0; rx_err = 0; usb_reset = 0;
    tx_req = 0; tx_done = 0; wait_rx = 0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_bus_ctrl.md
# usb_bus_ctrl

Half-duplex bus direction controller placed between the SIE, `phy_rx` and `phy_tx`. It shares the single USB dp/dn pair between receive and transmit:
- gates `phy_rx` through `rx_en_o`;
- enforces the inter-packet delay before granting transmission;
- times out when an expected host response does not arrive.

All timing is counted in 12 MHz bit times derived from `clk_i`.

## Interface
Parameters:
- `BIT_SAMPLES`, default 4: clk_i cycles per USB bit time (clk_i = 12 MHz × BIT_SAMPLES).
- `IPD_BITS`, default 2: minimum inter-packet delay, in bit times, from received EOP to tx grant.
- `TIMEOUT_BITS`, default 18: response timeout, in bit times, counted from end of transmission.

Ports:
- `clk_i` in 1: clock; one clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rx_valid_i` in 1: from phy_rx.
- `rx_ready_i` in 1: from phy_rx.
- `rx_err_i` in 1: from phy_rx.
- `usb_reset_i` in 1: from phy_rx.
- `rx_en_o` out 1: enable to phy_rx.
- `tx_req_i` in 1: SIE transmit request, level; held until grant.
- `wait_rx_i` in 1: SIE expects a response after this transmission; sampled on tx_done_i.
- `tx_done_i` in 1: one-cycle pulse from phy_tx when its EOP is complete.
- `tx_grant_o` out 1: SIE/phy_tx may drive the bus.
- `timeout_o` out 1: one-cycle pulse on response timeout.
- `err_cnt_o` out 8: error/timeout count; see Configuration.

## Operation
- State register `state_q` has six states: ST_IDLE, ST_RX, ST_IPD, ST_TX, ST_WAIT, ST_RST.
- Outputs decode `state_q`:
  - `rx_en_o` = 1 in every state except ST_TX.
  - `tx_grant_o` = 1 only in ST_TX.
- `cnt_q` clock counter:
  - width ceil_log2(TIMEOUT_BITS×BIT_SAMPLES+1);
  - cleared on every state change;
  - increments each cycle in ST_IPD and ST_WAIT;
  - holds otherwise.
- EOP = `rx_ready_i & ~rx_valid_i & ~rx_err_i`. Error = `rx_ready_i & rx_err_i`.
- Transitions, evaluated top-down, first match wins:
  - any state, `usb_reset_i`=1 → ST_RST. This includes ST_TX: the grant drops and the transmission is aborted.
  - ST_RST: `usb_reset_i`=0 → ST_IDLE.
  - ST_IDLE: `rx_valid_i`=1 → ST_RX; else `tx_req_i`=1 → ST_TX.
  - ST_RX: EOP → ST_IPD; error → ST_IDLE; otherwise stay.
  - ST_IPD: `rx_valid_i`=1 → ST_RX; `cnt_q`==IPD_BITS×BIT_SAMPLES−1 → ST_IDLE.
  - ST_TX: `tx_done_i`=1 → ST_WAIT if `wait_rx_i`=1, else ST_IDLE. `rx_*` inputs are ignored. `tx_req_i` falling does not leave ST_TX.
  - ST_WAIT: `rx_valid_i`=1 → ST_RX; `cnt_q`==TIMEOUT_BITS×BIT_SAMPLES−1 → ST_IDLE with `timeout_o`=1 for that one cycle.
- ST_WAIT, same cycle as timeout and `rx_valid_i`: the receive wins. Next state is ST_RX and there is no timeout pulse.
- A `tx_req_i` raised during ST_RX or ST_IPD stays pending and is granted from ST_IDLE.

## Timing
- Reset values:
  - `state_q`=ST_IDLE, `cnt_q`=0;
  - `rx_en_o`=1, `tx_grant_o`=0, `timeout_o`=0, `err_cnt_o`=0.
- All transitions are registered. An input sampled at edge N changes the outputs just after edge N.
- Latencies:
  - `tx_req_i` high in ST_IDLE → `tx_grant_o` high one cycle later.
  - `tx_done_i` → `tx_grant_o` low and `rx_en_o` high one cycle later.
- Minimum gap, EOP `rx_ready_i` pulse to `tx_grant_o` rise: IPD_BITS×BIT_SAMPLES+2 cycles. This is 10 cycles at defaults: 1 cycle into ST_IPD, 8 cycles counting, 1 cycle through ST_IDLE.
- Timeout: `timeout_o` rises TIMEOUT_BITS×BIT_SAMPLES+1 cycles after the `tx_done_i` edge. This is 73 cycles at defaults.
- `rst_i` asserted mid-operation: immediate asynchronous return to reset values, including `err_cnt_o`.

## Configuration
- Macro `USB_BUS_CTRL_ERR_CNT_EN`.
- Defined: `err_cnt_o` is an 8-bit saturating counter.
  - Increments by 1 on each ST_RX error exit and on each `timeout_o` pulse.
  - Holds at 255.
  - Cleared only by `rst_i`.
- Undefined: `err_cnt_o` is tied to 0 and no counter flops are instantiated.

## Test plan
- Receive then respond:
  - Stimulus: rx_valid_i high 20 cycles, then EOP pulse; tx_req_i held high.
  - Response: tx_grant_o rises exactly 10 cycles after the EOP pulse; rx_en_o low exactly while tx_grant_o is high.
- Timeout:
  - Stimulus: tx_done_i with wait_rx_i=1, no further rx activity.
  - Response: single-cycle timeout_o 73 cycles later, state back to ST_IDLE.
  - With `USB_BUS_CTRL_ERR_CNT_EN` defined: err_cnt_o=1.
- Timeout race:
  - Stimulus: rx_valid_i asserted in the exact cycle cnt_q reaches 71.
  - Response: ST_RX, no timeout_o, err_cnt_o unchanged.
- Reset abort:
  - Stimulus: usb_reset_i pulsed for 5 cycles while tx_grant_o=1.
  - Response: tx_grant_o low the next cycle, rx_en_o=1; ST_IDLE 1 cycle after usb_reset_i falls.
- Error saturation (with `USB_BUS_CTRL_ERR_CNT_EN` defined):
  - Stimulus: 300 rx error exits.
  - Response: err_cnt_o=255; tx_req_i during each error packet is granted 1 cycle after the error, with no IPD.
- Async reset:
  - Stimulus: rst_i asserted in ST_WAIT.
  - Response: all outputs at reset values before the next clk_i edge.
